// File: rtl/ntt_stage_sequencer_if.sv
// Control and memory/butterfly bus of the NTT stage sequencer.
// The master side is the sequencer. The slave side is the memory, the butterfly unit and the host.
interface ntt_stage_sequencer_if #(
   parameter int LOG_N = 8
);
   localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

   logic             start;
   logic             hold;
   logic             busy;
   logic             done;
   logic [SW-1:0]    stage;
   logic             mem_re;
   logic [LOG_N-1:0] mem_raddr_a;
   logic [LOG_N-1:0] mem_raddr_b;
   logic [LOG_N-1:0] tw_addr;
   logic             bf_valid_in;
   logic             mem_we;
   logic [LOG_N-1:0] mem_waddr_a;
   logic [LOG_N-1:0] mem_waddr_b;

   modport master (
      input  start, hold,
      output busy, done, stage, mem_re, mem_raddr_a, mem_raddr_b, tw_addr,
             bf_valid_in, mem_we, mem_waddr_a, mem_waddr_b
   );

   modport slave (
      output start, hold,
      input  busy, done, stage, mem_re, mem_raddr_a, mem_raddr_b, tw_addr,
             bf_valid_in, mem_we, mem_waddr_a, mem_waddr_b
   );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// In-place radix-2 NTT stage sequencer. It issues one butterfly pair per cycle, MSB pivot first.
// Write addresses replay the read addresses BF_LAT+1 cycles later, and the pipeline drains between stages.
module ntt_stage_sequencer #(
   parameter int LOG_N  = 8,
   parameter int BF_LAT = 3
) (
   input logic                   clk,
   input logic                   rst,
   ntt_stage_sequencer_if.master bus
);
   localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
   localparam int KW = LOG_N - 1;
   localparam int L  = BF_LAT + 1;
   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [SW-1:0]            s_q, s_d;
   logic [KW-1:0]            k_q, k_d;
   logic [L-1:0]             pv_q, pv_d;
   logic [L-1:0][LOG_N-1:0]  pa_q, pa_d;
   logic [L-1:0][LOG_N-1:0]  pb_q, pb_d;

   logic             issue;
   logic [SW-1:0]    pivot;
   logic [LOG_N-1:0] k_ext;
   logic [LOG_N-1:0] low_mask;
   logic [LOG_N-1:0] addr_a;
   logic [LOG_N-1:0] addr_b;
   logic [LOG_N-1:0] tw;

   // Insert a zero at the pivot bit of k to get the lower element. The upper element sets that bit.
   always_comb begin
      issue    = (state_q == ISSUE) && !bus.hold;
      pivot    = S_LAST - s_q;
      k_ext    = {1'b0, k_q};
      low_mask = (LOG_N'(1) << pivot) - LOG_N'(1);
      addr_a   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
      addr_b   = addr_a | (LOG_N'(1) << pivot);
      tw       = (LOG_N'(1) << s_q) + (k_ext >> pivot);
   end

   always_comb begin
      pv_d = {pv_q[L-2:0], issue};
      pa_d = {pa_q[L-2:0], (issue ? addr_a : LOG_N'(0))};
      pb_d = {pb_q[L-2:0], (issue ? addr_b : LOG_N'(0))};
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = ISSUE;
               s_d     = '0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (issue) begin
               if (k_q == K_LAST) begin
                  state_d = DRAIN;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         DRAIN: begin
            // Only the final pair is left in the pipe and it is writing this cycle.
            if (pv_q[L-2:0] == '0) begin
               k_d = '0;
               if (s_q == S_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  s_d     = s_q + SW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         k_q     <= '0;
         pv_q    <= '0;
         pa_q    <= '0;
         pb_q    <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         pv_q    <= pv_d;
         pa_q    <= pa_d;
         pb_q    <= pb_d;
      end
   end

   assign bus.busy        = (state_q == ISSUE) || (state_q == DRAIN);
   assign bus.done        = (state_q == DONE);
   assign bus.stage       = s_q;
   assign bus.mem_re      = issue;
   assign bus.mem_raddr_a = issue ? addr_a : '0;
   assign bus.mem_raddr_b = issue ? addr_b : '0;
   assign bus.tw_addr     = issue ? tw : '0;
   assign bus.bf_valid_in = pv_q[0];
   assign bus.mem_we      = pv_q[L-1];
   assign bus.mem_waddr_a = pa_q[L-1];
   assign bus.mem_waddr_b = pb_q[L-1];
endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
Top-level sequencer for an in-place radix-2 NTT over an N = 2^LOG_N point coefficient memory. It walks all LOG_N butterfly stages, with the pair distance starting at N/2 (MSB pivot) and halving each stage. Each cycle it issues one butterfly pair read, with its twiddle index, to a dual-port memory and a fixed-latency butterfly unit. It replays the same pair addresses as writes once the butterfly result is ready. It drains the pipeline between stages so no stage reads data before the previous stage's writes have committed.

Parameters:
LOG_N, 8, log2 of transform size; address width; stage count.
BF_LAT, 3, butterfly unit latency in cycles from bf_valid_in to result (>=1).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to run a full transform; ignored unless IDLE.
hold  in  1  pauses issuing new pairs; in-flight pairs continue.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  one-cycle pulse after final write of final stage.
stage  out  ceil(log2(LOG_N))  current stage index s.
mem_re  out  1  read strobe for both ports.
mem_raddr_a  out  LOG_N  read address, lower element of pair.
mem_raddr_b  out  LOG_N  read address, upper element of pair.
tw_addr  out  LOG_N  twiddle ROM address, valid with mem_re.
bf_valid_in  out  1  mem_re delayed 1 cycle (memory read latency 1).
mem_we  out  1  write strobe for both ports.
mem_waddr_a  out  LOG_N  write address, lower element.
mem_waddr_b  out  LOG_N  write address, upper element.

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE. Reset: IDLE, all outputs 0, stage=0, pair counter k=0, pipeline valids cleared.
- IDLE: start=1 -> ISSUE with s=0, k=0.
- ISSUE: k counts 0..N/2-1, one pair per cycle when hold=0. Pivot p = LOG_N-1-s.
- Address rule: addr_a = k with a 0 bit inserted at position p (bits above p shift up by one). addr_b = addr_a | (1<<p).
- Twiddle rule: tw_addr = (1<<s) + (k>>p), LOG_N bits wide, never overflows.
- hold=1 in ISSUE: mem_re=0 and k frozen. hold is ignored in other states.
- Issuing k=N/2-1 -> DRAIN.
- Write pipeline: shift register of {valid, addr_a, addr_b}, depth L = BF_LAT+1. mem_we and write addresses appear exactly L cycles after the matching mem_re cycle, independent of hold.
- DRAIN: wait until the last pair's write cycle. On the following cycle, either enter ISSUE with s+1 and k=0, or, if s=LOG_N-1, enter DONE. Stage period with no hold is N/2+L cycles.
- DONE: done=1 for one cycle, busy=0, then IDLE. stage holds the last value until the next start.
- start while busy or DONE is ignored (no queuing).
- rst asserted mid-transform: immediate return to IDLE. In-flight writes are discarded (mem_we=0 from the reset edge on). No done pulse.
- Reads and writes of the same stage may overlap. Cross-stage overlap never occurs.

Test Plan:
- LOG_N=3, BF_LAT=2, start at cycle 0, hold=0: stage0 reads (0,4),(1,5),(2,6),(3,7) in cycles 1-4 with tw=1. Writes repeat these pairs in cycles 4-7. Stage1 reads (0,2),(1,3),(4,6),(5,7) in cycles 8-11 with tw 2,2,3,3. Stage2 reads (0,1),(2,3),(4,5),(6,7) in cycles 15-18 with tw 4,5,6,7. Last write at cycle 21, done at 22, busy high cycles 1-21.
- Same config, hold=1 in cycles 2-3: pair (1,5) issues at cycle 4. Stage0 last write slips 2 cycles, to cycle 9. Every mem_we stays exactly 3 cycles after its mem_re.
- Start pulse at cycle 5 during a run: no effect. Exactly one done pulse, timing unchanged.
- Reset asserted at cycle 10: next edge shows busy=0, mem_we=0, mem_re=0. Start afterwards reruns from stage0 pair (0,4).
- Default LOG_N=8, BF_LAT=3: 8*(128+4) = 1056 cycles from first issue to done-1. Every address pair is written exactly once per stage, and addr_b-addr_a = 2^(7-s).
- Back-to-back: start in the cycle after done is accepted, and the run repeats identically.
